// File: rtl/dino_pkg.sv
// Shared state encoding and default tuning values for the dino game controller.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    AIR  = 2'd2,
    DEAD = 2'd3
  } state_e;

  localparam int JUMP_V0_DEF      = 4;
  localparam int GRAVITY_DEF      = 1;
  localparam int Y_W_DEF          = 7;
  localparam int SCORE_DIV_DEF    = 6;
  localparam int DEAD_HOLDOFF_DEF = 30;

endpackage

// File: rtl/dino_game_ctrl_if.sv
// Frame-rate game bus between the controller and the renderer/input logic.
interface dino_game_ctrl_if #(
  parameter int Y_W = dino_pkg::Y_W_DEF
);
  logic           frame_tick;
  logic           jump_btn;
  logic           collision;
  logic           halt;
  logic [Y_W-1:0] dino_y;
  logic           jumping;
  logic           game_over;
  logic [15:0]    score;

  modport master (output frame_tick, jump_btn, collision,
                  input  halt, dino_y, jumping, game_over, score);
  modport slave  (input  frame_tick, jump_btn, collision,
                  output halt, dino_y, jumping, game_over, score);
endinterface

// File: rtl/dino_jump_phys.sv
// Pure combinational jump physics: one frame of height/velocity update.
module dino_jump_phys
  import dino_pkg::*;
#(
  parameter int Y_W     = Y_W_DEF,
  parameter int GRAVITY = GRAVITY_DEF
) (
  input  logic [Y_W-1:0]        y_i,
  input  logic signed [Y_W:0]   vel_i,
  output logic [Y_W-1:0]        y_o,
  output logic signed [Y_W:0]   vel_o,
  output logic                  land_o
);
  localparam logic signed [Y_W:0]   G     = (Y_W+1)'(GRAVITY);
  localparam logic signed [Y_W+1:0] Y_MAX = (Y_W+2)'(2**Y_W - 1);

  // Sum is two bits wider than y so neither the climb nor the descent can wrap.
  logic signed [Y_W+1:0] sum;

  // Landing when the new height would be at or below ground; clamp at the ceiling.
  always_comb begin
    sum    = $signed({2'b00, y_i}) + $signed({vel_i[Y_W], vel_i});
    land_o = sum[Y_W+1] || (sum == '0);
    if (land_o)           y_o = '0;
    else if (sum > Y_MAX) y_o = '1;
    else                  y_o = sum[Y_W-1:0];
    vel_o  = vel_i - G;
  end
endmodule

// File: rtl/dino_game_ctrl.sv
// Dino game controller: run/jump/dead FSM, frame-paced scoring and death holdoff.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int JUMP_V0      = JUMP_V0_DEF,
  parameter int GRAVITY      = GRAVITY_DEF,
  parameter int Y_W          = Y_W_DEF,
  parameter int SCORE_DIV    = SCORE_DIV_DEF,
  parameter int DEAD_HOLDOFF = DEAD_HOLDOFF_DEF
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  dino_game_ctrl_if.slave  bus
);
  localparam int DIV_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int HO_W  = (DEAD_HOLDOFF > 0) ? $clog2(DEAD_HOLDOFF + 1) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCORE_DIV - 1);
  localparam logic [HO_W-1:0]   HO_LOAD  = HO_W'(DEAD_HOLDOFF);
  localparam logic signed [Y_W:0] V0     = (Y_W+1)'(JUMP_V0);

  state_e              state_q, state_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic signed [Y_W:0] vel_q, vel_d;
  logic [15:0]         score_q, score_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HO_W-1:0]     ho_q, ho_d;
  logic                pend_q, pend_d, btn_q, pend;

  logic [Y_W-1:0]      phys_y;
  logic signed [Y_W:0] phys_vel;
  logic                phys_land;

  dino_jump_phys #(.Y_W(Y_W), .GRAVITY(GRAVITY)) u_phys (
    .y_i   (y_q),
    .vel_i (vel_q),
    .y_o   (phys_y),
    .vel_o (phys_vel),
    .land_o(phys_land)
  );

  // Next state: everything advances only on frame_tick; the pending press is
  // captured every cycle and always consumed by the tick, acted on or not.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    score_d = score_q;
    div_d   = div_q;
    ho_d    = ho_q;
    pend    = pend_q | (bus.jump_btn & ~btn_q);
    pend_d  = pend;
    if (bus.frame_tick) begin
      pend_d = 1'b0;
      if (state_q == RUN || state_q == AIR) begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      case (state_q)
        IDLE: if (pend) begin
          state_d = RUN;
          score_d = '0;
          div_d   = '0;
        end
        RUN: if (bus.collision) begin
          state_d = DEAD;
          ho_d    = HO_LOAD;
        end else if (pend) begin
          state_d = AIR;
          vel_d   = V0;
        end
        AIR: if (bus.collision) begin
          state_d = DEAD;
          ho_d    = HO_LOAD;
        end else if (phys_land) begin
          state_d = RUN;
          y_d     = '0;
        end else begin
          y_d     = phys_y;
          vel_d   = phys_vel;
        end
        DEAD: if (ho_q != '0) begin
          ho_d    = ho_q - HO_W'(1);
        end else if (pend) begin
          state_d = RUN;
          score_d = '0;
          y_d     = '0;
          div_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      vel_q   <= '0;
      score_q <= '0;
      div_q   <= '0;
      ho_q    <= '0;
      pend_q  <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      score_q <= score_d;
      div_q   <= div_d;
      ho_q    <= ho_d;
      pend_q  <= pend_d;
      btn_q   <= bus.jump_btn;
    end
  end

  // Outputs decode only from registers.
  assign bus.halt      = (state_q == IDLE) || (state_q == DEAD);
  assign bus.jumping   = (state_q == AIR);
  assign bus.game_over = (state_q == DEAD);
  assign bus.dino_y    = y_q;
  assign bus.score     = score_q;
endmodule

// File: tb/tb_dino_game_ctrl.sv
// Self-checking bench for dino_game_ctrl against a frame-level game model.
module tb_dino_game_ctrl;
  localparam int V0 = 4, G = 1, YW = 7, SDIV = 6, HOLD = 30, YMAX = 127;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b1;
  always #5 clk = ~clk;

  dino_game_ctrl_if #(.Y_W(YW)) bus ();
  dino_game_ctrl_if #(.Y_W(YW)) sbus ();

  dino_game_ctrl #(.JUMP_V0(V0), .GRAVITY(G), .Y_W(YW), .SCORE_DIV(SDIV),
                   .DEAD_HOLDOFF(HOLD)) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .bus(bus));

  // Second instance with one point per frame, used to reach score saturation quickly.
  dino_game_ctrl #(.JUMP_V0(V0), .GRAVITY(G), .Y_W(YW), .SCORE_DIV(1),
                   .DEAD_HOLDOFF(HOLD)) dut_sat (
    .clk(clk), .sys_rst_n(sys_rst_n), .bus(sbus));

  int pass_cnt = 0, chk_cnt = 0;

  // Game model in plain integers.
  string m_mode;
  int    m_y, m_v, m_score, m_frames, m_hold;
  bit    m_pend;

  task automatic model_reset();
    m_mode = "idle"; m_y = 0; m_v = 0; m_score = 0; m_frames = 0; m_hold = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit c);
    bit p;
    int s;
    p = m_pend;
    m_pend = 0;
    if (m_mode == "run" || m_mode == "air") begin
      m_frames++;
      if (m_frames == SDIV) begin
        m_frames = 0;
        if (m_score < 65535) m_score++;
      end
    end
    if (m_mode == "idle") begin
      if (p) begin m_mode = "run"; m_score = 0; m_frames = 0; end
    end else if (m_mode == "run") begin
      if (c) begin m_mode = "dead"; m_hold = HOLD; end
      else if (p) begin m_mode = "air"; m_v = V0; end
    end else if (m_mode == "air") begin
      if (c) begin m_mode = "dead"; m_hold = HOLD; end
      else begin
        s = m_y + m_v;
        if (s <= 0) begin m_y = 0; m_mode = "run"; end
        else begin m_y = (s > YMAX) ? YMAX : s; m_v = m_v - G; end
      end
    end else begin
      if (m_hold > 0) m_hold--;
      else if (p) begin m_mode = "run"; m_score = 0; m_y = 0; m_frames = 0; end
    end
  endtask

  // One-cycle button pulse on a non-tick cycle, then a released cycle.
  task automatic press();
    bus.jump_btn = 1'b1;
    @(posedge clk); #1;
    bus.jump_btn = 1'b0;
    @(posedge clk); #1;
    m_pend = 1;
  endtask

  task automatic tick(input bit c);
    bus.frame_tick = 1'b1;
    bus.collision  = c;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    bus.collision  = 1'b0;
    model_step(c);
  endtask

  task automatic test_reset();
    #3 sys_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (bus.halt !== 1'b1) $display("FAIL rst_halt got %b exp 1", bus.halt); else pass_cnt++;
    chk_cnt++; if (bus.dino_y !== 7'd0) $display("FAIL rst_y got %0d exp 0", bus.dino_y); else pass_cnt++;
    chk_cnt++; if (bus.score !== 16'd0) $display("FAIL rst_score got %0d exp 0", bus.score); else pass_cnt++;
    chk_cnt++; if (bus.jumping !== 1'b0) $display("FAIL rst_jumping got %b exp 0", bus.jumping); else pass_cnt++;
    chk_cnt++; if (bus.game_over !== 1'b0) $display("FAIL rst_game_over got %b exp 0", bus.game_over); else pass_cnt++;
    sys_rst_n = 1'b1;
    model_reset();
    tick(0);
    chk_cnt++; if (bus.halt !== 1'b1) $display("FAIL idle_no_press_halt got %b exp 1", bus.halt); else pass_cnt++;
  endtask

  task automatic test_start();
    press();
    tick(0);
    chk_cnt++; if (bus.halt !== 1'b0) $display("FAIL start_halt got %b exp 0", bus.halt); else pass_cnt++;
    chk_cnt++; if (bus.score !== 16'd0) $display("FAIL start_score got %0d exp 0", bus.score); else pass_cnt++;
    chk_cnt++; if (bus.jumping !== 1'b0) $display("FAIL start_jumping got %b exp 0", bus.jumping); else pass_cnt++;
  endtask

  task automatic test_score();
    for (int i = 1; i <= 12; i++) begin
      tick(0);
      chk_cnt++; if (bus.score !== 16'(m_score)) $display("FAIL score_t%0d got %0d exp %0d", i, bus.score, m_score); else pass_cnt++;
    end
    chk_cnt++; if (bus.score !== 16'd2) $display("FAIL score_12 got %0d exp 2", bus.score); else pass_cnt++;
  endtask

  task automatic test_jump_arc();
    int arc [9];
    arc = '{4, 7, 9, 10, 10, 9, 7, 4, 0};
    press();
    tick(0);
    chk_cnt++; if (bus.jumping !== 1'b1) $display("FAIL arc_takeoff got %b exp 1", bus.jumping); else pass_cnt++;
    for (int i = 0; i < 9; i++) begin
      tick(0);
      chk_cnt++; if (bus.dino_y !== 7'(arc[i])) $display("FAIL arc_y%0d got %0d exp %0d", i, bus.dino_y, arc[i]); else pass_cnt++;
      chk_cnt++; if (bus.dino_y !== 7'(m_y)) $display("FAIL arc_model_y%0d got %0d exp %0d", i, bus.dino_y, m_y); else pass_cnt++;
      chk_cnt++; if (bus.score !== 16'(m_score)) $display("FAIL arc_score%0d got %0d exp %0d", i, bus.score, m_score); else pass_cnt++;
    end
    chk_cnt++; if (bus.jumping !== 1'b0) $display("FAIL arc_landed got %b exp 0", bus.jumping); else pass_cnt++;
    chk_cnt++; if (bus.halt !== 1'b0) $display("FAIL arc_landed_halt got %b exp 0", bus.halt); else pass_cnt++;
  endtask

  task automatic test_air_presses();
    press();
    tick(0);
    for (int i = 0; i < 3; i++) begin
      press();
      tick(0);
      chk_cnt++; if (bus.dino_y !== 7'(m_y)) $display("FAIL air_press_y%0d got %0d exp %0d", i, bus.dino_y, m_y); else pass_cnt++;
      chk_cnt++; if (bus.jumping !== 1'b1) $display("FAIL air_press_jumping%0d got %b exp 1", i, bus.jumping); else pass_cnt++;
    end
    // Reset mid-flight with a press still pending; outputs must clear before any edge.
    bus.jump_btn = 1'b1;
    @(posedge clk); #1;
    bus.jump_btn = 1'b0;
    sys_rst_n = 1'b0;
    #2;
    chk_cnt++; if (bus.dino_y !== 7'd0) $display("FAIL air_rst_y got %0d exp 0", bus.dino_y); else pass_cnt++;
    chk_cnt++; if (bus.jumping !== 1'b0) $display("FAIL air_rst_jumping got %b exp 0", bus.jumping); else pass_cnt++;
    chk_cnt++; if (bus.halt !== 1'b1) $display("FAIL air_rst_halt got %b exp 1", bus.halt); else pass_cnt++;
    chk_cnt++; if (bus.score !== 16'd0) $display("FAIL air_rst_score got %0d exp 0", bus.score); else pass_cnt++;
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    model_reset();
    tick(0);
    chk_cnt++; if (bus.halt !== 1'b1) $display("FAIL rst_no_residual got halt %b exp 1", bus.halt); else pass_cnt++;
  endtask

  task automatic test_collision_jump();
    press();
    tick(0);
    for (int i = 0; i < 3; i++) tick(0);
    press();
    tick(1);
    chk_cnt++; if (bus.game_over !== 1'b1) $display("FAIL coll_game_over got %b exp 1", bus.game_over); else pass_cnt++;
    chk_cnt++; if (bus.jumping !== 1'b0) $display("FAIL coll_jumping got %b exp 0", bus.jumping); else pass_cnt++;
    chk_cnt++; if (bus.halt !== 1'b1) $display("FAIL coll_halt got %b exp 1", bus.halt); else pass_cnt++;
  endtask

  task automatic test_holdoff();
    for (int i = 1; i <= HOLD; i++) begin
      if (i == 5 || i == HOLD) press();
      tick(0);
      chk_cnt++; if (bus.game_over !== 1'b1) $display("FAIL hold_t%0d got game_over %b exp 1", i, bus.game_over); else pass_cnt++;
      chk_cnt++; if (bus.score !== 16'(m_score)) $display("FAIL hold_score_t%0d got %0d exp %0d", i, bus.score, m_score); else pass_cnt++;
    end
    press();
    tick(0);
    chk_cnt++; if (bus.game_over !== 1'b0) $display("FAIL restart_game_over got %b exp 0", bus.game_over); else pass_cnt++;
    chk_cnt++; if (bus.halt !== 1'b0) $display("FAIL restart_halt got %b exp 0", bus.halt); else pass_cnt++;
    chk_cnt++; if (bus.score !== 16'd0) $display("FAIL restart_score got %0d exp 0", bus.score); else pass_cnt++;
    chk_cnt++; if (bus.dino_y !== 7'd0) $display("FAIL restart_y got %0d exp 0", bus.dino_y); else pass_cnt++;
  endtask

  task automatic test_random();
    bit c;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) press();
      c = ($urandom_range(11) == 0);
      tick(c);
      chk_cnt++; if (bus.dino_y !== 7'(m_y)) $display("FAIL rnd_y%0d got %0d exp %0d", i, bus.dino_y, m_y); else pass_cnt++;
      chk_cnt++; if (bus.score !== 16'(m_score)) $display("FAIL rnd_score%0d got %0d exp %0d", i, bus.score, m_score); else pass_cnt++;
      chk_cnt++; if (bus.jumping !== (m_mode == "air")) $display("FAIL rnd_jumping%0d got %b exp %b", i, bus.jumping, m_mode == "air"); else pass_cnt++;
      chk_cnt++; if (bus.game_over !== (m_mode == "dead")) $display("FAIL rnd_game_over%0d got %b exp %b", i, bus.game_over, m_mode == "dead"); else pass_cnt++;
      chk_cnt++; if (bus.halt !== (m_mode == "idle" || m_mode == "dead")) $display("FAIL rnd_halt%0d got %b", i, bus.halt); else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    int n;
    sys_rst_n = 1'b0;
    @(posedge clk); #1;
    sys_rst_n = 1'b1;
    model_reset();
    sbus.jump_btn = 1'b1;
    @(posedge clk); #1;
    sbus.jump_btn = 1'b0;
    sbus.frame_tick = 1'b1;
    @(posedge clk); #1;
    chk_cnt++; if (sbus.halt !== 1'b0) $display("FAIL sat_start_halt got %b exp 0", sbus.halt); else pass_cnt++;
    n = 65534;
    repeat (n) @(posedge clk);
    #1;
    chk_cnt++; if (sbus.score !== 16'hFFFE) $display("FAIL sat_fffe got %h exp fffe", sbus.score); else pass_cnt++;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      n = n + 1;
      chk_cnt++; if (sbus.score !== 16'((n > 65535) ? 65535 : n)) $display("FAIL sat_k%0d got %h exp ffff", k, sbus.score); else pass_cnt++;
    end
    sbus.frame_tick = 1'b0;
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.jump_btn = 1'b0; bus.collision = 1'b0;
    sbus.frame_tick = 1'b0; sbus.jump_btn = 1'b0; sbus.collision = 1'b0;
    model_reset();
    test_reset();
    test_start();
    test_score();
    test_jump_arc();
    test_air_presses();
    test_collision_jump();
    test_holdoff();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
